// File: rtl/hdr_buffer.sv
// Header buffer: gathers one ingress packet into a fixed header window, hands it to the parser
// and presents window, parser offsets and length downstream. Option: HDR_BUFFER_TRUNC_CNT_EN.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 32
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 3
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif

module hdr_buffer #(
    parameter int unsigned HdrMaxLen  = `HDR_MAX_LEN,
    parameter int unsigned NumHeaders = `NUM_HEADERS,
    parameter int unsigned DataBus    = `DATA_BUS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid_i,
    input  logic [`BYTE_BUS-1:0] byte_i,
    input  logic                 byte_last_i,
    output logic                 byte_ready_o,
    output logic                 start_o,
    output logic [`BYTE_BUS-1:0] pkt_hdr_o [0:HdrMaxLen-1],
    input  logic                 parse_ready_i,
    input  logic [DataBus-1:0]   parsed_hdrs_i [NumHeaders-1:0],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataBus-1:0]   parsed_hdrs_o [NumHeaders-1:0],
`ifdef HDR_BUFFER_TRUNC_CNT_EN
    output logic [DataBus-1:0]   trunc_cnt_o,
`endif
    output logic [DataBus-1:0]   pkt_len_o
);

    localparam int unsigned IdxW = (HdrMaxLen > 1) ? $clog2(HdrMaxLen) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StIssue,
        StParse,
        StOut
    } state_e;

    state_e               state_q;
    logic [DataBus-1:0]   cnt_q;
    logic                 first_q;
    logic                 start_q;
    logic                 out_valid_q;
    logic                 ready_q;
    logic [`BYTE_BUS-1:0] hdr_q [0:HdrMaxLen-1];
    logic [DataBus-1:0]   parsed_q [NumHeaders-1:0];
    logic                 accept;
`ifdef HDR_BUFFER_TRUNC_CNT_EN
    logic [DataBus-1:0]   trunc_q;
`endif

    assign accept = byte_valid_i & ready_q;

    always_ff @(posedge clk) begin
        if (rst == `TRUE) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            for (int i = 0; i < HdrMaxLen; i++) hdr_q[i] <= '0;
            for (int i = 0; i < NumHeaders; i++) parsed_q[i] <= DataBus'(`NO_HEADER);
`ifdef HDR_BUFFER_TRUNC_CNT_EN
            trunc_q     <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        hdr_q[0] <= byte_i;
                        cnt_q    <= DataBus'(1);
                        if (byte_last_i) begin
                            state_q <= StIssue;
                            start_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFill: begin
                    if (accept) begin
                        // Bytes past the window are counted but not stored.
                        if (cnt_q < DataBus'(HdrMaxLen)) hdr_q[cnt_q[IdxW-1:0]] <= byte_i;
                        cnt_q <= cnt_q + DataBus'(1);
                        if (byte_last_i) begin
                            state_q <= StIssue;
                            start_q <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StParse;
                    first_q <= 1'b1;
`ifdef HDR_BUFFER_TRUNC_CNT_EN
                    if (cnt_q > DataBus'(HdrMaxLen) && trunc_q != '1) begin
                        trunc_q <= trunc_q + DataBus'(1);
                    end
`endif
                end
                StParse: begin
                    // The parser's ready is still stale in the first cycle after start.
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (parse_ready_i) begin
                        parsed_q    <= parsed_hdrs_i;
                        state_q     <= StOut;
                        out_valid_q <= 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready_i) begin
                        for (int i = 0; i < HdrMaxLen; i++) hdr_q[i] <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready_o  = ready_q;
    assign start_o       = start_q;
    assign out_valid_o   = out_valid_q;
    assign pkt_len_o     = cnt_q;
    assign pkt_hdr_o     = hdr_q;
    assign parsed_hdrs_o = parsed_q;
`ifdef HDR_BUFFER_TRUNC_CNT_EN
    assign trunc_cnt_o   = trunc_q;
`endif

endmodule

// File: tb/tb_hdr_buffer.sv
// Bench for hdr_buffer: table of directed packets, reset corner cases and random packets
// checked against a byte-queue model of the header window, length and parser offsets.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 32
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 3
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif

module tb_hdr_buffer;
    localparam int MAX = `HDR_MAX_LEN;
    localparam int NH  = `NUM_HEADERS;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid_i, byte_last_i, byte_ready_o, start_o;
    logic [7:0]  byte_i;
    logic [7:0]  pkt_hdr_o [0:MAX-1];
    logic        parse_ready_i, out_valid_o, out_ready_i;
    logic [31:0] parsed_hdrs_i [NH-1:0];
    logic [31:0] parsed_hdrs_o [NH-1:0];
    logic [31:0] pkt_len_o;
`ifdef HDR_BUFFER_TRUNC_CNT_EN
    logic [31:0] trunc_cnt_o;
`endif

    hdr_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .byte_valid_i  (byte_valid_i),
        .byte_i        (byte_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .start_o       (start_o),
        .pkt_hdr_o     (pkt_hdr_o),
        .parse_ready_i (parse_ready_i),
        .parsed_hdrs_i (parsed_hdrs_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .parsed_hdrs_o (parsed_hdrs_o),
`ifdef HDR_BUFFER_TRUNC_CNT_EN
        .trunc_cnt_o   (trunc_cnt_o),
`endif
        .pkt_len_o     (pkt_len_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int lat;
        int hold;
        bit fixed_offs;
        int exp_len;
        int exp_trunc_inc;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          exp_trunc = 0;
    logic [7:0]  data_q[$];
    logic [31:0] exp_offs [NH-1:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_window(input string name);
        for (int i = 0; i < MAX; i++) begin
            check($sformatf("%s[%0d]", name, i), {24'h0, pkt_hdr_o[i]},
                  (i < data_q.size()) ? {24'h0, data_q[i]} : 32'h0);
        end
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < MAX; i++) check($sformatf("%s[%0d]", name, i), {24'h0, pkt_hdr_o[i]}, 0);
    endtask

    task automatic check_offs(input string name);
        for (int i = 0; i < NH; i++) check($sformatf("%s[%0d]", name, i), parsed_hdrs_o[i], exp_offs[i]);
    endtask

    task automatic run_pkt(input int len, input bit rand_data, input int lat, input int hold,
                           input bit fixed_offs, input int exp_len, input int trunc_inc);
        int guard;
        data_q.delete();
        for (int i = 0; i < len; i++) data_q.push_back(rand_data ? 8'($urandom) : 8'(i));
        guard = 0;
        while (byte_ready_o !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        check("ingress_ready", {31'h0, byte_ready_o}, 1);
        for (int i = 0; i < len; i++) begin
            if (rand_data && $urandom_range(0, 3) == 0) begin
                byte_valid_i = 1'b0;
                byte_last_i  = 1'($urandom);
                step();
            end
            byte_valid_i = 1'b1;
            byte_i       = data_q[i];
            byte_last_i  = (i == len - 1);
            if (i == len - 1) check("start_before_last", {31'h0, start_o}, 0);
            step();
        end
        // Cycle T+1: ISSUE
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        out_ready_i  = 1'($urandom);
        check("start_issue", {31'h0, start_o}, 1);
        check("len_issue", pkt_len_o, exp_len);
        check("ready_issue", {31'h0, byte_ready_o}, 0);
        check("valid_issue", {31'h0, out_valid_o}, 0);
        check_window("hdr_issue");
        step();
        // Cycle T+2: first PARSE cycle, parser ready still stale-high
        exp_trunc += trunc_inc;
        check("start_parse", {31'h0, start_o}, 0);
`ifdef HDR_BUFFER_TRUNC_CNT_EN
        check("trunc_cnt", trunc_cnt_o, exp_trunc);
`endif
        step();
        check("early_out", {31'h0, out_valid_o}, 0);
        parse_ready_i = 1'b0;
        out_ready_i   = 1'($urandom);
        for (int k = 1; k < lat; k++) begin
            step();
            check("wait_parse", {31'h0, out_valid_o}, 0);
            out_ready_i = 1'($urandom);
        end
        step();
        check("pre_out", {31'h0, out_valid_o}, 0);
        for (int i = 0; i < NH; i++) begin
            if (fixed_offs) exp_offs[i] = (i == 0) ? 32'd14 : (i == 1) ? 32'd34 : `NO_HEADER;
            else exp_offs[i] = $urandom;
            parsed_hdrs_i[i] = exp_offs[i];
        end
        parse_ready_i = 1'b1;
        step();
        // First OUT cycle
        out_ready_i = 1'b0;
        for (int i = 0; i < NH; i++) parsed_hdrs_i[i] = $urandom;
        byte_valid_i = 1'b1;
        byte_i       = 8'($urandom);
        byte_last_i  = 1'($urandom);
        check("out_valid", {31'h0, out_valid_o}, 1);
        check("ready_out", {31'h0, byte_ready_o}, 0);
        check("len_out", pkt_len_o, exp_len);
        check_offs("offs_out");
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", {31'h0, out_valid_o}, 1);
            check("hold_ready", {31'h0, byte_ready_o}, 0);
            check("hold_len", pkt_len_o, exp_len);
            check_offs("hold_offs");
        end
        check_window("hdr_out");
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        out_ready_i  = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("valid_after", {31'h0, out_valid_o}, 0);
        check("ready_after", {31'h0, byte_ready_o}, 1);
        check_zero("hdr_cleared");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        int   len;
        vecs[0] = '{20, 1, 10, 1'b1, 20, 0};
        vecs[1] = '{MAX + 6, 2, 1, 1'b0, MAX + 6, 1};
        vecs[2] = '{1, 1, 0, 1'b0, 1, 0};
        vecs[3] = '{MAX, 3, 2, 1'b0, MAX, 0};
        vecs[4] = '{MAX + 1, 1, 0, 1'b0, MAX + 1, 1};

        rst = 1'b1;
        byte_valid_i = 1'b0;
        byte_i = 8'h0;
        byte_last_i = 1'b0;
        parse_ready_i = 1'b1;
        out_ready_i = 1'b0;
        for (int i = 0; i < NH; i++) parsed_hdrs_i[i] = 32'h0;
        data_q.delete();
        step();
        step();
        check("rst_ready", {31'h0, byte_ready_o}, 0);
        check("rst_start", {31'h0, start_o}, 0);
        check("rst_valid", {31'h0, out_valid_o}, 0);
        check("rst_len", pkt_len_o, 0);
        for (int i = 0; i < NH; i++) exp_offs[i] = `NO_HEADER;
        check_offs("rst_offs");
        check_zero("rst_hdr");
`ifdef HDR_BUFFER_TRUNC_CNT_EN
        check("rst_trunc", trunc_cnt_o, 0);
`endif
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'h0, byte_ready_o}, 1);

        for (int v = 0; v < 5; v++) begin
            run_pkt(vecs[v].len, 1'b0, vecs[v].lat, vecs[v].hold, vecs[v].fixed_offs,
                    vecs[v].exp_len, vecs[v].exp_trunc_inc);
        end

        // Reset while byte 7 of a 20-byte packet is presented
        for (int i = 0; i < 7; i++) begin
            byte_valid_i = 1'b1;
            byte_i       = 8'(8'hA0 + i);
            byte_last_i  = 1'b0;
            if (i == 6) rst = 1'b1;
            step();
        end
        byte_valid_i = 1'b0;
        step();
        check("fill_rst_ready", {31'h0, byte_ready_o}, 0);
        check("fill_rst_len", pkt_len_o, 0);
        check_zero("fill_rst_hdr");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("fill_rst_start", {31'h0, start_o}, 0);
            check("fill_rst_valid", {31'h0, out_valid_o}, 0);
        end
        check("fill_rst_ready_back", {31'h0, byte_ready_o}, 1);

        // Reset during PARSE
        for (int i = 0; i < 10; i++) begin
            byte_valid_i = 1'b1;
            byte_i       = 8'(8'h50 + i);
            byte_last_i  = (i == 9);
            step();
        end
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        check("parse_rst_start", {31'h0, start_o}, 1);
        step();
        step();
        rst = 1'b1;
        parse_ready_i = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check("parse_rst_start_none", {31'h0, start_o}, 0);
            check("parse_rst_valid_none", {31'h0, out_valid_o}, 0);
        end
        check_zero("parse_rst_hdr");
        run_pkt(3, 1'b1, 1, 1, 1'b0, 3, 0);

        // Random packets against the queue model
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(1, MAX + 10);
            run_pkt(len, 1'b1, $urandom_range(1, 4), $urandom_range(0, 3), 1'b0, len,
                    (len > MAX) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
